lane_rr_scheduler: RTL and testbench
====================================

LANE_RR_SCHEDULER -- requirements
Module: lane_rr_scheduler

Interface
REQ-001 The block SHALL have parameter IDLE_SYM, default 8'hBC, which is the symbol driven on data_out when no lane is transmitting.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, which is the maximum number of words taken from one lane per grant (legal range 1..15).
REQ-003 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports data_0p, data_1p, data_2p and data_3p, input, 8 bits each: per-lane head-of-queue data.
REQ-006 The block SHALL have ports valid_0p, valid_1p, valid_2p and valid_3p, input, 1 bit each: per-lane data available.
REQ-007 The block SHALL have port out_ready, input, 1 bit: downstream accepts a word this cycle.
REQ-008 The block SHALL have ports pop_0p, pop_1p, pop_2p and pop_3p, output, 1 bit each: combinational dequeue strobe to the lane queue.
REQ-009 The block SHALL have port data_out, output, 8 bits: registered serialized word or IDLE_SYM.
REQ-010 The block SHALL have port valid_out, output, 1 bit: registered; data_out carries lane data.
REQ-011 The block SHALL have port grant, output, 2 bits: registered index of the lane currently or most recently granted.
REQ-012 The block SHALL have port idle_out, output, 1 bit: high while the FSM is in IDLE.

Function
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 Internal state SHALL be last_grant (2 bits), burst_cnt (4 bits) and the FSM state.
REQ-015 In IDLE with out_ready=1 and at least one valid, the block SHALL select the first valid lane searching from last_grant+1 upward, modulo 4.
REQ-016 In the same cycle as REQ-015, the block SHALL assert that lane's pop; at the next edge: grant<=lane, data_out<=lane data, valid_out<=1, burst_cnt<=1, state<=SEND.
REQ-017 Latency from valid sampled in IDLE to data_out valid SHALL be exactly 1 clk_4f cycle.
REQ-018 In IDLE with no valid, or with out_ready=0, the block SHALL assert no pop and drive data_out<=IDLE_SYM, valid_out<=0.
REQ-019 In SEND, pop[grant] SHALL be out_ready & valid[grant] & (burst_cnt<MAX_BURST).
REQ-020 In SEND when popping, the block SHALL set data_out<=data[grant], valid_out<=1, burst_cnt<=burst_cnt+1.
REQ-021 In SEND with out_ready=1 and no pop (burst limit reached or valid[grant] low), the block SHALL set state<=IDLE, data_out<=IDLE_SYM, valid_out<=0, last_grant<=grant.
REQ-022 Consecutive bursts SHALL always be separated by at least one IDLE_SYM cycle.
REQ-023 In SEND with out_ready=0 (stall), the block SHALL assert no pop and hold data_out, valid_out, grant, burst_cnt and state unchanged.
REQ-024 At most one pop output SHALL be high in any cycle.
REQ-025 No pop SHALL be asserted while reset is high.
REQ-026 Valid on non-granted lanes SHALL be ignored during SEND.
REQ-027 Arbitration SHALL be fair: with all lanes continuously valid, the grant order is 0,1,2,3,0,...
REQ-028 burst_cnt SHALL never exceed MAX_BURST and SHALL not wrap.

Reset
REQ-029 While reset=1, asynchronously and independent of clk_4f: state=IDLE, data_out=IDLE_SYM, valid_out=0, grant=0, last_grant=3, burst_cnt=0, idle_out=1.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately with no further pop.
REQ-031 After reset release, the first grant SHALL go to the lowest-numbered valid lane starting from lane 0.

Verification
REQ-032 Reset: assert reset with random inputs -> data_out=8'hBC, valid_out=0, grant=0, all pops 0, idle_out=1.
REQ-033 Lane 2 only, continuously valid, data 0x10,0x11,..., out_ready=1 -> data_out 0x10-0x13 valid, one 0xBC cycle, then 0x14-0x17; grant=2.
REQ-034 All lanes valid, out_ready=1 -> four-word bursts from lanes 0,1,2,3,0, each followed by one 0xBC cycle; pops one-hot.
REQ-035 out_ready low for 3 cycles after 2nd word of lane 0 -> no pops, outputs frozen; then words 3-4 and exactly 4 pops total.
REQ-036 Lane 1 valid drops after 2 words, lane 3 valid -> 2 words from lane 1, one 0xBC cycle, then lane 3 granted (lane 2 skipped).
REQ-037 Reset pulse mid-burst on lane 3 -> immediate 0xBC/valid_out=0; after release with lanes 0 and 3 valid, lane 0 is granted first.

Source files
------------

// File: rtl/lane_rr_scheduler.sv
// lane_rr_scheduler
//
// Round-robin serializer for four lane queues. The scheduler grants one lane
// at a time and takes a burst of up to MAX_BURST words from it onto a single
// 8-bit output. Every burst is followed by at least one IDLE_SYM cycle. The
// search for the next lane starts at the lane after the one granted last.
//
// Handshake: a lane word moves when that lane's pop strobe is high in a cycle.
// The pop strobe is combinational and is only raised when three things hold
// in that cycle: out_ready is high, the lane's valid is high, and the burst
// budget allows another word. The word appears on data_out with valid_out=1
// after the next rising edge. While out_ready is low during a burst, every
// output and all internal state hold.
//
// Ports
//   clk_4f                     : clock, rising edge
//   reset                      : asynchronous, active-high
//   data_0p..data_3p   [7:0]   : per-lane head-of-queue data
//   valid_0p..valid_3p         : per-lane data available
//   out_ready                  : downstream accepts a word this cycle
//   pop_0p..pop_3p             : combinational dequeue strobes (at most one high)
//   data_out           [7:0]   : registered lane word, or IDLE_SYM
//   valid_out                  : registered, data_out carries lane data
//   grant              [1:0]   : registered index of current / most recent lane
//   idle_out                   : high while the FSM is in IDLE (state visibility)

module lane_rr_scheduler #(
    parameter logic [7:0] IDLE_SYM  = 8'hBC,
    parameter int         MAX_BURST = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_0p,
    input  logic [7:0] data_1p,
    input  logic [7:0] data_2p,
    input  logic [7:0] data_3p,
    input  logic       valid_0p,
    input  logic       valid_1p,
    input  logic       valid_2p,
    input  logic       valid_3p,
    input  logic       out_ready,
    output logic       pop_0p,
    output logic       pop_1p,
    output logic       pop_2p,
    output logic       pop_3p,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant,
    output logic       idle_out
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [3:0] burst_cnt;

    logic [3:0] valid_vec;
    logic [1:0] sel_lane;
    logic       sel_found;
    logic [1:0] pop_lane;
    logic       do_pop;
    logic [7:0] pop_data;
    logic [3:0] pop_vec;

    assign valid_vec = {valid_3p, valid_2p, valid_1p, valid_0p};

    // Round-robin search: try last_grant+1, +2, +3, then last_grant itself.
    always_comb begin
        sel_lane  = last_grant;
        sel_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] cand;
            cand = last_grant + 2'(k);
            if (!sel_found && valid_vec[cand]) begin
                sel_lane  = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Pop decision. In SEND only the granted lane is considered, so valids on
    // other lanes have no effect until the burst ends. Reset masks all pops.
    always_comb begin
        do_pop   = 1'b0;
        pop_lane = grant;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (out_ready && sel_found) begin
                        do_pop   = 1'b1;
                        pop_lane = sel_lane;
                    end
                end
                SEND: begin
                    if (out_ready && valid_vec[grant] && (burst_cnt < MAX_CNT)) begin
                        do_pop   = 1'b1;
                        pop_lane = grant;
                    end
                end
                default: begin
                    do_pop   = 1'b0;
                    pop_lane = grant;
                end
            endcase
        end
    end

    always_comb begin
        case (pop_lane)
            2'd0:    pop_data = data_0p;
            2'd1:    pop_data = data_1p;
            2'd2:    pop_data = data_2p;
            default: pop_data = data_3p;
        endcase
    end

    always_comb begin
        pop_vec = 4'b0000;
        if (do_pop) pop_vec[pop_lane] = 1'b1;
    end

    assign pop_0p = pop_vec[0];
    assign pop_1p = pop_vec[1];
    assign pop_2p = pop_vec[2];
    assign pop_3p = pop_vec[3];

    assign idle_out = (state == IDLE);

    // last_grant resets to 3 so the first search after reset starts at lane 0.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            burst_cnt  <= 4'd0;
            grant      <= 2'd0;
            data_out   <= IDLE_SYM;
            valid_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        grant     <= pop_lane;
                        data_out  <= pop_data;
                        valid_out <= 1'b1;
                        burst_cnt <= 4'd1;
                        state     <= SEND;
                    end else begin
                        data_out  <= IDLE_SYM;
                        valid_out <= 1'b0;
                    end
                end
                SEND: begin
                    // out_ready low is a stall: nothing changes.
                    if (out_ready) begin
                        if (do_pop) begin
                            data_out  <= pop_data;
                            valid_out <= 1'b1;
                            burst_cnt <= burst_cnt + 4'd1;
                        end else begin
                            // Burst over (budget spent or lane ran dry); the
                            // IDLE cycle guarantees the separating IDLE_SYM.
                            state      <= IDLE;
                            data_out   <= IDLE_SYM;
                            valid_out  <= 1'b0;
                            last_grant <= grant;
                            burst_cnt  <= 4'd0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    data_out  <= IDLE_SYM;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_rr_scheduler.sv
// Testbench for lane_rr_scheduler: directed scenarios plus a randomized phase,
// checked against a lane/burst-level reference model and an expected-word queue.

module tb_lane_rr_scheduler;

    localparam logic [7:0] IDLE_SYM  = 8'hBC;
    localparam int         MAX_BURST = 4;

    // ---------------- clock / reset ----------------
    logic clk_4f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_4f = ~clk_4f;

    logic [7:0] data_0p, data_1p, data_2p, data_3p;
    logic       valid_0p, valid_1p, valid_2p, valid_3p;
    logic       out_ready;
    logic       pop_0p, pop_1p, pop_2p, pop_3p;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] grant;
    logic       idle_out;

    lane_rr_scheduler #(
        .IDLE_SYM  (IDLE_SYM),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_0p   (data_0p),
        .data_1p   (data_1p),
        .data_2p   (data_2p),
        .data_3p   (data_3p),
        .valid_0p  (valid_0p),
        .valid_1p  (valid_1p),
        .valid_2p  (valid_2p),
        .valid_3p  (valid_3p),
        .out_ready (out_ready),
        .pop_0p    (pop_0p),
        .pop_1p    (pop_1p),
        .pop_2p    (pop_2p),
        .pop_3p    (pop_3p),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant     (grant),
        .idle_out  (idle_out)
    );

    // ---------------- stimulus state ----------------
    logic [3:0] en  = 4'b0000;   // lane valids to drive
    logic       rdy = 1'b0;      // out_ready to drive
    logic [7:0] head [4];        // head-of-queue word per lane
    int         pops_seen [4];

    // ---------------- reference model ----------------
    int         m_lane;          // lane owning the current burst, -1 between bursts
    int         m_taken;         // words taken in current burst
    int         m_last;          // lane of the last completed burst
    int         m_grant;
    bit         m_valid;
    logic [7:0] held;
    logic [7:0] exp_q [$];
    logic [7:0] out_log [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        valid_0p  = en[0];
        valid_1p  = en[1];
        valid_2p  = en[2];
        valid_3p  = en[3];
        data_0p   = head[0];
        data_1p   = head[1];
        data_2p   = head[2];
        data_3p   = head[3];
        out_ready = rdy;
    endtask

    task automatic model_reset();
        m_lane  = -1;
        m_taken = 0;
        m_last  = 3;
        m_grant = 0;
        m_valid = 1'b0;
        held    = IDLE_SYM;
        exp_q.delete();
        for (int i = 0; i < 4; i++) pops_seen[i] = 0;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cycle();
        int         exp_l;
        logic [3:0] exp_pop;
        logic [3:0] dut_pop;
        drive();
        @(negedge clk_4f);
        exp_l = -1;
        if (!reset) begin
            if (m_lane < 0) begin
                if (rdy) begin
                    for (int k = 1; k <= 4; k++) begin
                        int l;
                        l = (m_last + k) % 4;
                        if (exp_l < 0 && en[l]) exp_l = l;
                    end
                end
            end else if (rdy && en[m_lane] && m_taken < MAX_BURST) begin
                exp_l = m_lane;
            end
        end
        exp_pop = (exp_l >= 0) ? (4'b0001 << exp_l) : 4'b0000;
        dut_pop = {pop_3p, pop_2p, pop_1p, pop_0p};
        check("pop", 32'(dut_pop), 32'(exp_pop));
        if (exp_l >= 0) exp_q.push_back(head[exp_l]);
        @(posedge clk_4f);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (dut_pop[i]) begin
                head[i]      = head[i] + 8'd1;
                pops_seen[i] = pops_seen[i] + 1;
            end
        end
        if (!reset) begin
            if (m_lane < 0) begin
                if (exp_l >= 0) begin
                    m_lane  = exp_l;
                    m_taken = 1;
                    m_grant = exp_l;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end else if (rdy) begin
                if (exp_l >= 0) begin
                    m_taken++;
                end else begin
                    m_last  = m_lane;
                    m_lane  = -1;
                    m_valid = 1'b0;
                end
            end
        end
        if (exp_l >= 0 && exp_q.size() > 0) held = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(m_valid ? held : IDLE_SYM));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("grant", 32'(grant), 32'(m_grant));
        check("idle_out", 32'(idle_out), 32'(m_lane < 0));
        out_log.push_back(data_out);
    endtask

    // Asynchronous reset pulse mid-cycle with random inputs; entered at posedge+1.
    task automatic do_reset();
        en  = 4'($urandom);
        rdy = 1'($urandom);
        drive();
        #2;
        reset = 1'b1;
        #1;
        check("rst_data", 32'(data_out), 32'(IDLE_SYM));
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_idle", 32'(idle_out), 32'd1);
        check("rst_pops", 32'({pop_3p, pop_2p, pop_1p, pop_0p}), 32'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        en    = 4'b0000;
        rdy   = 1'b0;
        out_log.delete();
    endtask

    logic [7:0] exp33 [9] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hBC, 8'h14, 8'h15, 8'h16, 8'h17};
    int         exp34 [5] = '{0, 1, 2, 3, 0};
    int         gq [$];
    logic       pv;
    logic [7:0] frozen;

    initial begin
        for (int i = 0; i < 4; i++) head[i] = 8'($urandom);
        model_reset();
        drive();
        repeat (2) @(posedge clk_4f);
        #1;

        // Lane 2 alone: two 4-word bursts separated by one idle symbol.
        do_reset();
        head[2] = 8'h10;
        en      = 4'b0100;
        rdy     = 1'b1;
        repeat (9) cycle();
        for (int i = 0; i < 9; i++) check("s33_word", 32'(out_log[i]), 32'(exp33[i]));
        check("s33_grant", 32'(grant), 32'd2);

        // All lanes valid: fair grant order.
        do_reset();
        en  = 4'b1111;
        rdy = 1'b1;
        pv  = 1'b0;
        gq.delete();
        repeat (25) begin
            cycle();
            if (valid_out && !pv) gq.push_back(int'(grant));
            pv = valid_out;
        end
        check("s34_bursts", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) check("s34_order", 32'(gq[i]), 32'(exp34[i]));
        end

        // Stall after the second word of lane 0.
        do_reset();
        en  = 4'b0001;
        rdy = 1'b1;
        repeat (2) cycle();
        frozen = data_out;
        rdy    = 1'b0;
        repeat (3) begin
            cycle();
            check("s35_frozen", 32'(data_out), 32'(frozen));
        end
        rdy = 1'b1;
        repeat (2) cycle();
        check("s35_pops", 32'(pops_seen[0]), 32'd4);

        // Lane 1 dries up after two words; lane 3 follows, lane 2 skipped.
        do_reset();
        en  = 4'b1010;
        rdy = 1'b1;
        repeat (2) cycle();
        en[1] = 1'b0;
        cycle();
        check("s36_gap", 32'(data_out), 32'(IDLE_SYM));
        cycle();
        check("s36_grant", 32'(grant), 32'd3);
        check("s36_valid", 32'(valid_out), 32'd1);
        check("s36_lane1_pops", 32'(pops_seen[1]), 32'd2);

        // Reset in the middle of a lane 3 burst; lane 0 wins afterwards.
        do_reset();
        en  = 4'b1000;
        rdy = 1'b1;
        repeat (3) cycle();
        check("s37_in_burst", 32'(valid_out), 32'd1);
        do_reset();
        en  = 4'b1001;
        rdy = 1'b1;
        cycle();
        check("s37_first_grant", 32'(grant), 32'd0);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 4; i++) head[i] = 8'($urandom);
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) en = 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
